// File: rtl/user_edge_result_fifo.sv
// -----------------------------------------------------------------------------
// user_edge_result_fifo
//
// Result buffer sitting behind the edge-detection accelerator. Output pixels
// arrive over a valid/ready stream, are stored as {last, pixel} entries and
// are handed to the core through a small OBI subordinate register block.
//
// Register map (word offset inside the 4 KiB window, byte enables ignored):
//   0x00 DATA   (R)   read pops one entry: {valid[31], last[8], pixel[7:0]}
//   0x04 STATUS       count[4:0], full[8], empty[9],
//                     stall_seen[16] (W1C), frame_done[17] (W1C)
//   0x08 CTRL         irq_en[0] RW, clear[1] write-1 self-clearing
//   0x0C THRESH       [4:0] RW, irq fill-level threshold
//   0x10 PIXCNT (R)   accepted-push counter, only with USER_EDGE_FIFO_STATS_EN
//   any other offset  err=1, rdata=0, no side effect
//
// Optional feature macro: USER_EDGE_FIFO_STATS_EN (adds PIXCNT).
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   pix_valid_i  accelerator pixel valid
//   pix_ready_o  buffer can accept a pixel (!full)
//   pix_data_i   pixel value
//   pix_last_i   last pixel of a frame
//   obi_req_i    OBI subordinate request
//   obi_rsp_o    OBI subordinate response (gnt same cycle, rvalid one later)
//   irq_o        level interrupt, registered
// -----------------------------------------------------------------------------

package user_edge_obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{
        AddrWidth: 32'd32,
        DataWidth: 32'd32,
        IdWidth:   32'd4
    };

    typedef struct packed {
        logic [SbrObiCfg.AddrWidth-1:0]   addr;
        logic                             we;
        logic [SbrObiCfg.DataWidth/8-1:0] be;
        logic [SbrObiCfg.DataWidth-1:0]   wdata;
        logic [SbrObiCfg.IdWidth-1:0]     aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [SbrObiCfg.DataWidth-1:0] rdata;
        logic [SbrObiCfg.IdWidth-1:0]   rid;
        logic                           err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        sbr_obi_r_chan_t r;
    } sbr_obi_rsp_t;

endpackage

module user_edge_result_fifo #(
    parameter user_edge_obi_pkg::obi_cfg_t ObiCfg = user_edge_obi_pkg::SbrObiCfg,
    parameter type obi_req_t                     = user_edge_obi_pkg::sbr_obi_req_t,
    parameter type obi_rsp_t                     = user_edge_obi_pkg::sbr_obi_rsp_t,
    parameter int unsigned Depth                 = 16,
    parameter int unsigned PixelWidth            = 8,
    parameter int unsigned IrqThreshold          = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    input  logic [PixelWidth-1:0] pix_data_i,
    input  logic                  pix_last_i,
    input  obi_req_t              obi_req_i,
    output obi_rsp_t              obi_rsp_o,
    output logic                  irq_o
);

    localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth   = PtrWidth + 1;
    localparam int unsigned EntryWidth = PixelWidth + 1;
    localparam int unsigned IdWidth    = ObiCfg.IdWidth;

    localparam logic [CntWidth-1:0] DepthCnt    = CntWidth'(Depth);
    localparam logic [4:0]          ThreshReset = 5'(IrqThreshold);

    localparam logic [9:0] IdxData   = 10'd0;
    localparam logic [9:0] IdxStatus = 10'd1;
    localparam logic [9:0] IdxCtrl   = 10'd2;
    localparam logic [9:0] IdxThresh = 10'd3;
`ifdef USER_EDGE_FIFO_STATS_EN
    localparam logic [9:0] IdxPixcnt = 10'd4;
`endif

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // DATA word; an empty FIFO reads as all zeros, including the valid bit.
    function automatic logic [31:0] pack_data_word(input logic                  valid,
                                                   input logic [EntryWidth-1:0] entry);
        logic [31:0] word;
        word = 32'h0000_0000;
        if (valid) begin
            word[31]             = 1'b1;
            word[8]              = entry[PixelWidth];
            word[PixelWidth-1:0] = entry[PixelWidth-1:0];
        end else begin
            word = 32'h0000_0000;
        end
        return word;
    endfunction

    function automatic logic [31:0] pack_status(input logic [4:0] cnt,
                                                input logic       full,
                                                input logic       empty,
                                                input logic       stall,
                                                input logic       done);
        logic [31:0] word;
        word      = 32'h0000_0000;
        word[4:0] = cnt;
        word[8]   = full;
        word[9]   = empty;
        word[16]  = stall;
        word[17]  = done;
        return word;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [EntryWidth-1:0] mem_r [Depth];
    logic [PtrWidth-1:0]   wr_ptr_r, wr_ptr_next_s;
    logic [PtrWidth-1:0]   rd_ptr_r, rd_ptr_next_s;
    logic [CntWidth-1:0]   count_r, count_next_s;
    logic                  stall_seen_r, stall_seen_next_s;
    logic                  frame_done_r, frame_done_next_s;
    logic                  irq_en_r, irq_en_next_s;
    logic [4:0]            thresh_r, thresh_next_s;
    logic                  irq_r, irq_next_s;

    logic                  rvalid_r;
    logic [31:0]           rdata_r, rdata_next_s;
    logic                  err_r, err_next_s;
    logic [IdWidth-1:0]    rid_r;

`ifdef USER_EDGE_FIFO_STATS_EN
    logic [31:0]           pixcnt_r, pixcnt_next_s;
    logic                  sel_pixcnt_s;
`endif

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic        req_s;
    logic        we_s;
    logic [31:0] wdata_s;
    logic [9:0]  word_idx_s;
    logic        sel_data_s, sel_status_s, sel_ctrl_s, sel_thresh_s;
    logic        map_hit_s;

    logic        full_s, empty_s;
    logic        pop_s, push_s, clear_s, stall_set_s, done_set_s;
    logic        status_wr_s, ctrl_wr_s, thresh_wr_s;
    logic [EntryWidth-1:0] head_entry_s;

    assign req_s      = obi_req_i.req;
    assign we_s       = obi_req_i.a.we;
    assign wdata_s    = obi_req_i.a.wdata;
    assign word_idx_s = obi_req_i.a.addr[11:2];

    // Byte enables and the bits outside the word index carry no meaning here.
    logic unused_s;
    assign unused_s = ^{obi_req_i.a.be, obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0],
                        wdata_s[31:18], wdata_s[15:5]};

    // One-hot register select from the word offset.
    always_comb begin
        sel_data_s   = 1'b0;
        sel_status_s = 1'b0;
        sel_ctrl_s   = 1'b0;
        sel_thresh_s = 1'b0;
`ifdef USER_EDGE_FIFO_STATS_EN
        sel_pixcnt_s = 1'b0;
`endif
        case (word_idx_s)
            IdxData:   sel_data_s   = 1'b1;
            IdxStatus: sel_status_s = 1'b1;
            IdxCtrl:   sel_ctrl_s   = 1'b1;
            IdxThresh: sel_thresh_s = 1'b1;
`ifdef USER_EDGE_FIFO_STATS_EN
            IdxPixcnt: sel_pixcnt_s = 1'b1;
`endif
            default:   sel_data_s   = 1'b0;
        endcase
    end

`ifdef USER_EDGE_FIFO_STATS_EN
    assign map_hit_s = sel_data_s | sel_status_s | sel_ctrl_s | sel_thresh_s | sel_pixcnt_s;
`else
    assign map_hit_s = sel_data_s | sel_status_s | sel_ctrl_s | sel_thresh_s;
`endif

    // -------------------------------------------------------------------------
    // FIFO control strobes
    // -------------------------------------------------------------------------
    assign full_s  = (count_r == DepthCnt);
    assign empty_s = (count_r == {CntWidth{1'b0}});

    // Ready only looks at the registered count, never at the OBI side.
    assign pix_ready_o = ~full_s;

    assign status_wr_s  = req_s & we_s & sel_status_s;
    assign ctrl_wr_s    = req_s & we_s & sel_ctrl_s;
    assign thresh_wr_s  = req_s & we_s & sel_thresh_s;
    assign clear_s      = ctrl_wr_s & wdata_s[1];
    // A pop on an empty FIFO is a no-op; a same-cycle push is not forwarded.
    assign pop_s        = req_s & ~we_s & sel_data_s & ~empty_s;
    // A clear wins over a concurrent push: that pixel is dropped.
    assign push_s       = pix_valid_i & ~full_s & ~clear_s;
    assign stall_set_s  = pix_valid_i & full_s;
    assign done_set_s   = push_s & pix_last_i;
    assign head_entry_s = mem_r[rd_ptr_r];

    // Next-state for pointers, fill level, sticky flags and control fields.
    always_comb begin
        wr_ptr_next_s     = wr_ptr_r;
        rd_ptr_next_s     = rd_ptr_r;
        count_next_s      = count_r;
        stall_seen_next_s = stall_seen_r;
        frame_done_next_s = frame_done_r;
        irq_en_next_s     = irq_en_r;
        thresh_next_s     = thresh_r;

        if (clear_s) begin
            wr_ptr_next_s     = {PtrWidth{1'b0}};
            rd_ptr_next_s     = {PtrWidth{1'b0}};
            count_next_s      = {CntWidth{1'b0}};
            stall_seen_next_s = 1'b0;
            frame_done_next_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + PtrWidth'(1'b1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PtrWidth'(1'b1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end

            // Push is gated by !full, so the count never passes Depth.
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CntWidth'(1'b1);
                2'b01:   count_next_s = count_r - CntWidth'(1'b1);
                default: count_next_s = count_r;
            endcase

            // Setting events beat a same-cycle W1C.
            if (stall_set_s) begin
                stall_seen_next_s = 1'b1;
            end else if (status_wr_s && wdata_s[16]) begin
                stall_seen_next_s = 1'b0;
            end else begin
                stall_seen_next_s = stall_seen_r;
            end

            if (done_set_s) begin
                frame_done_next_s = 1'b1;
            end else if (status_wr_s && wdata_s[17]) begin
                frame_done_next_s = 1'b0;
            end else begin
                frame_done_next_s = frame_done_r;
            end
        end

        if (ctrl_wr_s) begin
            irq_en_next_s = wdata_s[0];
        end else begin
            irq_en_next_s = irq_en_r;
        end

        if (thresh_wr_s) begin
            thresh_next_s = wdata_s[4:0];
        end else begin
            thresh_next_s = thresh_r;
        end
    end

    // irq_o is registered, so it reflects the state committed at this edge.
    assign irq_next_s = irq_en_next_s &
                        ((32'(count_next_s) >= 32'(thresh_next_s)) | frame_done_next_s);

`ifdef USER_EDGE_FIFO_STATS_EN
    // Accepted-push counter, wraps naturally at 2^32.
    always_comb begin
        if (clear_s) begin
            pixcnt_next_s = 32'h0000_0000;
        end else if (push_s) begin
            pixcnt_next_s = pixcnt_r + 32'd1;
        end else begin
            pixcnt_next_s = pixcnt_r;
        end
    end
`endif

    // Read data and error for the response issued on the next cycle.
    always_comb begin
        rdata_next_s = 32'h0000_0000;
        err_next_s   = 1'b0;
        if (req_s) begin
            if (!map_hit_s) begin
                err_next_s = 1'b1;
            end else if (!we_s) begin
                if (sel_data_s) begin
                    rdata_next_s = pack_data_word(~empty_s, head_entry_s);
                end else if (sel_status_s) begin
                    rdata_next_s = pack_status(5'(count_r), full_s, empty_s,
                                               stall_seen_r, frame_done_r);
                end else if (sel_ctrl_s) begin
                    rdata_next_s = {31'h0000_0000, irq_en_r};
                end else if (sel_thresh_s) begin
                    rdata_next_s = {27'h000_0000, thresh_r};
`ifdef USER_EDGE_FIFO_STATS_EN
                end else if (sel_pixcnt_s) begin
                    rdata_next_s = pixcnt_r;
`endif
                end else begin
                    rdata_next_s = 32'h0000_0000;
                end
            end else begin
                rdata_next_s = 32'h0000_0000;
            end
        end else begin
            err_next_s = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------

    // FIFO bookkeeping, control registers and the interrupt line.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r     <= {PtrWidth{1'b0}};
            rd_ptr_r     <= {PtrWidth{1'b0}};
            count_r      <= {CntWidth{1'b0}};
            stall_seen_r <= 1'b0;
            frame_done_r <= 1'b0;
            irq_en_r     <= 1'b0;
            thresh_r     <= ThreshReset;
            irq_r        <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            count_r      <= count_next_s;
            stall_seen_r <= stall_seen_next_s;
            frame_done_r <= frame_done_next_s;
            irq_en_r     <= irq_en_next_s;
            thresh_r     <= thresh_next_s;
            irq_r        <= irq_next_s;
        end
    end

    // Entry storage; contents are meaningless outside [rd_ptr, wr_ptr).
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {pix_last_i, pix_data_i};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // OBI response channel, one cycle behind the granted request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
            rid_r    <= {IdWidth{1'b0}};
        end else begin
            rvalid_r <= req_s;
            rdata_r  <= rdata_next_s;
            err_r    <= err_next_s;
            if (req_s) begin
                rid_r <= obi_req_i.a.aid;
            end else begin
                rid_r <= {IdWidth{1'b0}};
            end
        end
    end

`ifdef USER_EDGE_FIFO_STATS_EN
    // Accepted-push counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pixcnt_r <= 32'h0000_0000;
        end else begin
            pixcnt_r <= pixcnt_next_s;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------

    // Grant is immediate: the block never back-pressures the core.
    always_comb begin
        obi_rsp_o         = '0;
        obi_rsp_o.gnt     = req_s;
        obi_rsp_o.rvalid  = rvalid_r;
        obi_rsp_o.r.rdata = rdata_r;
        obi_rsp_o.r.rid   = rid_r;
        obi_rsp_o.r.err   = err_r;
    end

    assign irq_o = irq_r;

endmodule

// File: tb/tb_user_edge_result_fifo.sv
// Self-checking bench for user_edge_result_fifo: a directed vector table,
// hand-written corner sequences and a randomized run, all compared against a
// queue-based model of the register map.
module tb_user_edge_result_fifo;
    import user_edge_obi_pkg::*;

    localparam int DEPTH = 16;
`ifdef USER_EDGE_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic [7:0]   pix_data = 8'h00;
    logic         pix_last = 1'b0;
    sbr_obi_req_t obi_req;
    sbr_obi_rsp_t obi_rsp;
    logic         irq;

    user_edge_result_fifo #(
        .Depth        (16),
        .PixelWidth   (8),
        .IrqThreshold (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .pix_valid_i (pix_valid),
        .pix_ready_o (pix_ready),
        .pix_data_i  (pix_data),
        .pix_last_i  (pix_last),
        .obi_req_i   (obi_req),
        .obi_rsp_o   (obi_rsp),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [8:0]  m_q[$];
    logic        m_stall, m_fd, m_irq_en;
    logic [4:0]  m_thresh;
    logic [31:0] m_pixcnt;

    typedef struct packed {
        logic        pv;
        logic [7:0]  pd;
        logic        pl;
        logic        req;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [31:0] rdata;
        logic        err;
        logic        irq;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic stim_t mk_idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t mk_push(input logic [7:0] pd, input logic pl);
        stim_t s;
        s = '0;
        s.pv = 1'b1;
        s.pd = pd;
        s.pl = pl;
        return s;
    endfunction

    function automatic stim_t mk_rd(input logic [11:0] addr);
        stim_t s;
        s = '0;
        s.req  = 1'b1;
        s.addr = addr;
        return s;
    endfunction

    function automatic stim_t mk_wr(input logic [11:0] addr, input logic [31:0] wdata);
        stim_t s;
        s = '0;
        s.req   = 1'b1;
        s.we    = 1'b1;
        s.addr  = addr;
        s.wdata = wdata;
        return s;
    endfunction

    function automatic stim_t with_push(input stim_t base, input logic [7:0] pd, input logic pl);
        stim_t s;
        s    = base;
        s.pv = 1'b1;
        s.pd = pd;
        s.pl = pl;
        return s;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] w;
        w      = 32'h0;
        w[4:0] = 5'(m_q.size());
        w[8]   = (m_q.size() == DEPTH);
        w[9]   = (m_q.size() == 0);
        w[16]  = m_stall;
        w[17]  = m_fd;
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_stall  = 1'b0;
        m_fd     = 1'b0;
        m_irq_en = 1'b0;
        m_thresh = 5'd8;
        m_pixcnt = 32'h0;
    endtask

    // Apply one cycle of stimulus, advance the model and compare the DUT.
    task automatic cycle(input stim_t s);
        logic [9:0]  idx;
        logic        hit, ready_pre, pop, push, clr, exp_err, exp_irq;
        logic [31:0] exp_rdata;
        logic [3:0]  aid;
        aid = 4'($urandom);
        pix_valid         = s.pv;
        pix_data          = s.pd;
        pix_last          = s.pl;
        obi_req.req       = s.req;
        obi_req.a.we      = s.we;
        obi_req.a.addr    = {20'h00000, s.addr};
        obi_req.a.be      = 4'hF;
        obi_req.a.wdata   = s.wdata;
        obi_req.a.aid     = aid;
        #1;
        ready_pre = (m_q.size() < DEPTH);
        check1("gnt", obi_rsp.gnt, s.req);
        check1("pix_ready_pre", pix_ready, ready_pre);

        idx       = s.addr[11:2];
        hit       = (idx < 10'd4) || (STATS && idx == 10'd4);
        exp_err   = s.req && !hit;
        exp_rdata = 32'h0;
        if (s.req && !s.we && hit) begin
            case (idx)
                10'd0:   exp_rdata = (m_q.size() > 0) ? {1'b1, 22'h0, m_q[0]} : 32'h0;
                10'd1:   exp_rdata = m_status();
                10'd2:   exp_rdata = {31'h0, m_irq_en};
                10'd3:   exp_rdata = {27'h0, m_thresh};
                default: exp_rdata = m_pixcnt;
            endcase
        end
        clr  = s.req && s.we && idx == 10'd2 && s.wdata[1];
        pop  = s.req && !s.we && idx == 10'd0 && m_q.size() > 0;
        push = s.pv && ready_pre && !clr;
        if (clr) begin
            m_q.delete();
            m_stall  = 1'b0;
            m_fd     = 1'b0;
            m_pixcnt = 32'h0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({s.pl, s.pd});
                m_pixcnt++;
            end
            if (s.pv && !ready_pre) m_stall = 1'b1;
            else if (s.req && s.we && idx == 10'd1 && s.wdata[16]) m_stall = 1'b0;
            if (push && s.pl) m_fd = 1'b1;
            else if (s.req && s.we && idx == 10'd1 && s.wdata[17]) m_fd = 1'b0;
        end
        if (s.req && s.we && idx == 10'd2) m_irq_en = s.wdata[0];
        if (s.req && s.we && idx == 10'd3) m_thresh = s.wdata[4:0];
        exp_irq = m_irq_en && ((m_q.size() >= int'(m_thresh)) || m_fd);

        @(posedge clk);
        #1;
        check1("rvalid", obi_rsp.rvalid, s.req);
        if (s.req) begin
            check32("rdata", obi_rsp.r.rdata, exp_rdata);
            check1("err", obi_rsp.r.err, exp_err);
            check32("rid", 32'(obi_rsp.r.rid), 32'(aid));
        end
        check1("irq", irq, exp_irq);
        check1("pix_ready_post", pix_ready, m_q.size() < DEPTH);
    endtask

    task automatic do_reset(input int cycles);
        rst_ni    = 1'b0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        obi_req   = '0;
        repeat (cycles) @(posedge clk);
        #1;
        model_reset();
        check1("reset_ready", pix_ready, 1'b1);
        check1("reset_irq", irq, 1'b0);
        check1("reset_rvalid", obi_rsp.rvalid, 1'b0);
        check32("reset_rdata", obi_rsp.r.rdata, 32'h0);
        check1("reset_err", obi_rsp.r.err, 1'b0);
        rst_ni = 1'b1;
    endtask

    task automatic run_table();
        vec_t tbl[22];
        tbl[0]  = '{mk_push(8'h11, 1'b0),               32'h0,        1'b0,   1'b0};
        tbl[1]  = '{mk_push(8'h22, 1'b0),               32'h0,        1'b0,   1'b0};
        tbl[2]  = '{mk_push(8'h33, 1'b1),               32'h0,        1'b0,   1'b0};
        tbl[3]  = '{mk_rd(12'h000),                     32'h80000011, 1'b0,   1'b0};
        tbl[4]  = '{mk_rd(12'h000),                     32'h80000022, 1'b0,   1'b0};
        tbl[5]  = '{mk_rd(12'h000),                     32'h80000133, 1'b0,   1'b0};
        tbl[6]  = '{mk_rd(12'h004),                     32'h00020200, 1'b0,   1'b0};
        tbl[7]  = '{mk_wr(12'h004, 32'h00030000),       32'h0,        1'b0,   1'b0};
        tbl[8]  = '{mk_rd(12'h004),                     32'h00000200, 1'b0,   1'b0};
        tbl[9]  = '{mk_rd(12'h020),                     32'h0,        1'b1,   1'b0};
        tbl[10] = '{mk_rd(12'h010), STATS ? 32'd3 : 32'd0,            !STATS, 1'b0};
        tbl[11] = '{mk_wr(12'h00C, 32'h2),              32'h0,        1'b0,   1'b0};
        tbl[12] = '{mk_wr(12'h008, 32'h1),              32'h0,        1'b0,   1'b0};
        tbl[13] = '{mk_push(8'hAA, 1'b0),               32'h0,        1'b0,   1'b0};
        tbl[14] = '{mk_push(8'hBB, 1'b1),               32'h0,        1'b0,   1'b1};
        tbl[15] = '{mk_rd(12'h008),                     32'h1,        1'b0,   1'b1};
        tbl[16] = '{mk_rd(12'h00C),                     32'h2,        1'b0,   1'b1};
        tbl[17] = '{with_push(mk_wr(12'h008, 32'h3), 8'hCC, 1'b0), 32'h0, 1'b0, 1'b0};
        tbl[18] = '{mk_rd(12'h004),                     32'h00000200, 1'b0,   1'b0};
        tbl[19] = '{with_push(mk_rd(12'h000), 8'h55, 1'b0), 32'h0,    1'b0,   1'b0};
        tbl[20] = '{mk_rd(12'h000),                     32'h80000055, 1'b0,   1'b0};
        tbl[21] = '{mk_wr(12'h008, 32'h0),              32'h0,        1'b0,   1'b0};
        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].s);
            if (tbl[i].s.req && !tbl[i].s.we) begin
                check32($sformatf("tbl%0d_rdata", i), obi_rsp.r.rdata, tbl[i].rdata);
                check1($sformatf("tbl%0d_err", i), obi_rsp.r.err, tbl[i].err);
            end
            check1($sformatf("tbl%0d_irq", i), irq, tbl[i].irq);
        end
    endtask

    task automatic run_directed();
        // Fill to full, then stall
        for (int i = 0; i < 16; i++) cycle(mk_push(8'(i), 1'b0));
        cycle(mk_push(8'hEE, 1'b0));
        check1("full_ready_low", pix_ready, 1'b0);
        cycle(with_push(mk_rd(12'h004), 8'hEE, 1'b0));
        check32("full_status", obi_rsp.r.rdata, 32'h00010110);
        cycle(mk_rd(12'h000));
        check32("full_pop_head", obi_rsp.r.rdata, 32'h80000000);
        check1("full_ready_after_pop", pix_ready, 1'b1);
        for (int i = 0; i < 15; i++) cycle(mk_rd(12'h000));
        cycle(mk_wr(12'h004, 32'h00010000));

        // Threshold interrupt
        cycle(mk_wr(12'h008, 32'h2));
        cycle(mk_wr(12'h00C, 32'h4));
        cycle(mk_wr(12'h008, 32'h1));
        for (int i = 0; i < 3; i++) cycle(mk_push(8'h40 + 8'(i), 1'b0));
        check1("irq_below_thresh", irq, 1'b0);
        cycle(mk_push(8'h43, 1'b0));
        check1("irq_at_thresh", irq, 1'b1);
        cycle(mk_rd(12'h000));
        check1("irq_after_pop", irq, 1'b0);

        // Clear with a concurrent push into a FIFO holding 3 entries
        cycle(mk_wr(12'h008, 32'h2));
        for (int i = 0; i < 3; i++) cycle(mk_push(8'h60 + 8'(i), 1'b0));
        cycle(with_push(mk_wr(12'h008, 32'h2), 8'h77, 1'b1));
        cycle(mk_rd(12'h004));
        check32("clear_status", obi_rsp.r.rdata, 32'h00000200);
        cycle(mk_rd(12'h000));
        check32("clear_push_lost", obi_rsp.r.rdata, 32'h0);

`ifdef USER_EDGE_FIFO_STATS_EN
        for (int i = 0; i < 5; i++) cycle(mk_push(8'h90 + 8'(i), 1'b0));
        cycle(mk_rd(12'h010));
        check32("pixcnt_five", obi_rsp.r.rdata, 32'd5);
        cycle(mk_wr(12'h010, 32'hFFFFFFFF));
        check1("pixcnt_write_err", obi_rsp.r.err, 1'b0);
        cycle(mk_wr(12'h008, 32'h2));
        cycle(mk_rd(12'h010));
        check32("pixcnt_cleared", obi_rsp.r.rdata, 32'd0);
`endif

        // Reset in the middle of operation discards everything
        for (int i = 0; i < 3; i++) cycle(mk_push(8'hA0 + 8'(i), 1'b1));
        cycle(mk_wr(12'h00C, 32'h1));
        cycle(mk_wr(12'h008, 32'h1));
        do_reset(2);
        cycle(mk_rd(12'h004));
        check32("midreset_status", obi_rsp.r.rdata, 32'h00000200);
        cycle(mk_rd(12'h00C));
        check32("midreset_thresh", obi_rsp.r.rdata, 32'h8);
        check1("midreset_irq", irq, 1'b0);
    endtask

    task automatic run_random(input int n);
        stim_t s;
        int    sel;
        for (int i = 0; i < n; i++) begin
            s    = '0;
            s.pv = (i < n / 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            s.pd = 8'($urandom);
            s.pl = ($urandom_range(0, 7) == 0);
            s.req = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: s.addr = 12'h000;
                4:          s.addr = 12'h004;
                5:          s.addr = 12'h008;
                6:          s.addr = 12'h00C;
                7:          s.addr = 12'h010;
                8:          s.addr = 12'h020;
                default:    s.addr = {10'($urandom_range(5, 1023)), 2'b00};
            endcase
            s.we    = (sel < 4) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
            s.wdata = $urandom;
            if ($urandom_range(0, 7) != 0) s.wdata[1] = 1'b0;
            cycle(s);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        obi_req = '0;
        model_reset();
        @(posedge clk);
        do_reset(3);
        run_table();
        run_directed();
        run_random(3000);
        cycle(mk_idle());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
